// File: rtl/serial_frame_loader_if.sv
// Output frame handshake between serial_frame_loader and the downstream layer.
interface serial_frame_loader_if #(
  parameter int NUM_INPUTS = 784,
  parameter int DATA_WIDTH = 16
);
  logic [NUM_INPUTS*DATA_WIDTH-1:0] dataOut;
  logic                             outValid;
  logic                             outReady;

  modport master (output dataOut, output outValid, input outReady);
  modport slave  (input dataOut, input outValid, output outReady);
endinterface

// File: rtl/serial_frame_loader.sv
// Serial-to-parallel frame loader: synchronises host serial lanes, assembles a
// frame and hands it downstream through a double-buffered valid/ready output.
module serial_frame_loader #(
  parameter int NUM_INPUTS  = 784,
  parameter int DATA_WIDTH  = 16,
  parameter int LANES       = 1,
  parameter int SYNC_STAGES = 2,
  localparam int WPL        = NUM_INPUTS / LANES,
  localparam int LANE_BITS  = WPL * DATA_WIDTH,
  localparam int CW         = $clog2(LANE_BITS + 1)
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 serialClock,
  input  logic [LANES-1:0]     serialData,
  input  logic                 serialLatch,
  serial_frame_loader_if.master out_if,
  output logic                 frameError,
  output logic [CW-1:0]        bitCount
);

  localparam int FW = NUM_INPUTS * DATA_WIDTH;
  localparam logic [CW-1:0] LANE_BITS_C = CW'(LANE_BITS);

  typedef enum logic [1:0] {RECV, FULL, PEND} state_t;

  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0]            sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0]            latch_sync_q, latch_sync_d;
  logic [SYNC_STAGES-1:0][LANES-1:0] sdata_sync_q, sdata_sync_d;
  logic sclk_prev_q, sclk_prev_d, latch_prev_q, latch_prev_d;
  logic [FW-1:0] asm_q, asm_d, data_q, data_d;
  logic          valid_q, valid_d, err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clk_edge, latch_edge, consume, out_free, transfer;
  logic [LANES-1:0] lane_bits;

  // Data and clock share the same depth so each edge sees its own data bit.
  always_comb begin
    sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], serialClock};
    latch_sync_d = {latch_sync_q[SYNC_STAGES-2:0], serialLatch};
    sdata_sync_d = {sdata_sync_q[SYNC_STAGES-2:0], serialData};
    sclk_prev_d  = sclk_sync_q[SYNC_STAGES-1];
    latch_prev_d = latch_sync_q[SYNC_STAGES-1];
  end

  assign clk_edge   = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign latch_edge = latch_sync_q[SYNC_STAGES-1] & ~latch_prev_q;
  assign lane_bits  = sdata_sync_q[SYNC_STAGES-1];
  assign consume    = valid_q & out_if.outReady;
  assign out_free   = ~valid_q | consume;

  always_comb begin
    state_d  = state_q;
    asm_d    = asm_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    valid_d  = valid_q & ~consume;
    err_d    = err_q;
    transfer = 1'b0;
    unique case (state_q)
      RECV: begin
        // A latch wins over a coincident clock edge, judged on the old count.
        if (latch_edge) begin
          cnt_d = '0;
          err_d = 1'b1;
        end else if (clk_edge && cnt_q < LANE_BITS_C) begin
          for (int unsigned l = 0; l < LANES; l++) begin
            asm_d[l*LANE_BITS +: LANE_BITS] =
              {asm_q[l*LANE_BITS +: LANE_BITS-1], lane_bits[l]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == LANE_BITS_C) state_d = FULL;
        end
      end
      FULL: begin
        if (clk_edge) err_d = 1'b1;
        if (latch_edge) begin
          if (out_free) transfer = 1'b1;
          else          state_d  = PEND;
        end
      end
      PEND: begin
        if (clk_edge) err_d = 1'b1;
        if (out_free) transfer = 1'b1;
      end
      default: state_d = RECV;
    endcase
    if (transfer) begin
      data_d  = asm_q;
      valid_d = 1'b1;
      cnt_d   = '0;
      state_d = RECV;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= RECV;
      sclk_sync_q  <= '0;
      latch_sync_q <= '0;
      sdata_sync_q <= '0;
      sclk_prev_q  <= 1'b0;
      latch_prev_q <= 1'b0;
      asm_q        <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      sclk_sync_q  <= sclk_sync_d;
      latch_sync_q <= latch_sync_d;
      sdata_sync_q <= sdata_sync_d;
      sclk_prev_q  <= sclk_prev_d;
      latch_prev_q <= latch_prev_d;
      asm_q        <= asm_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_if.dataOut  = data_q;
  assign out_if.outValid = valid_q;
  assign frameError      = err_q;
  assign bitCount        = cnt_q;

endmodule

// File: tb/tb_serial_frame_loader.sv
// Directed/randomised bench for serial_frame_loader with a word-level frame model.
module tb_serial_frame_loader;

  localparam int NI  = 4;
  localparam int DW  = 8;
  localparam int L   = 2;
  localparam int SS  = 2;
  localparam int WPL = NI / L;
  localparam int LB  = WPL * DW;
  localparam int FW  = NI * DW;
  localparam int CW  = $clog2(LB + 1);

  typedef logic [FW-1:0] frame_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          serialClock;
  logic [L-1:0]  serialData;
  logic          serialLatch;
  logic          frameError;
  logic [CW-1:0] bitCount;

  int checks = 0;
  int errors = 0;

  serial_frame_loader_if #(.NUM_INPUTS(NI), .DATA_WIDTH(DW)) out_if ();

  serial_frame_loader #(
    .NUM_INPUTS(NI), .DATA_WIDTH(DW), .LANES(L), .SYNC_STAGES(SS)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .serialClock(serialClock),
    .serialData(serialData), .serialLatch(serialLatch), .out_if(out_if),
    .frameError(frameError), .bitCount(bitCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: lane l carries words l*WPL+WPL-1 down to l*WPL, each MSB first.
  function automatic logic lane_bit(input frame_t f, input int l, input int b);
    int w, idx;
    w   = l*WPL + WPL - 1 - b / DW;
    idx = w*DW + DW - 1 - (b % DW);
    return f[idx];
  endfunction

  function automatic logic [L-1:0] bits_at(input frame_t f, input int b);
    logic [L-1:0] d;
    for (int l = 0; l < L; l++) d[l] = (b < LB) ? lane_bit(f, l, b) : 1'($urandom);
    return d;
  endfunction

  task automatic clk_pulse(input logic [L-1:0] d);
    serialData = d;
    tick(1);
    serialClock = 1'b1;
    tick(4);
    serialClock = 1'b0;
    tick(4);
  endtask

  task automatic send(input frame_t f, input int n);
    for (int b = 0; b < n; b++) clk_pulse(bits_at(f, b));
  endtask

  task automatic latch();
    serialLatch = 1'b1;
    tick(4);
    serialLatch = 1'b0;
    tick(4);
  endtask

  task automatic consume();
    out_if.outReady = 1'b1;
    tick(1);
    out_if.outReady = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  initial begin
    frame_t f, fa, fb;
    reset = 1'b1; serialClock = 1'b0; serialData = '0; serialLatch = 1'b0;
    out_if.outReady = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("rst_data",  out_if.dataOut, 0);
    chk("rst_valid", out_if.outValid, 0);
    chk("rst_err",   frameError, 0);
    chk("rst_cnt",   bitCount, 0);

    // Basic frame with latch-to-valid latency
    f = 32'h44332211;
    send(f, 15);
    chk("basic_cnt15", bitCount, 15);
    send(f[FW-1:0] , 0);
    clk_pulse(bits_at(f, 15));
    chk("basic_cnt16", bitCount, 16);
    serialLatch = 1'b1;
    tick(2);
    chk("basic_lat2_valid", out_if.outValid, 0);
    tick(1);
    chk("basic_lat3_valid", out_if.outValid, 1);
    chk("basic_data", out_if.dataOut, 64'h44332211);
    chk("basic_cnt0", bitCount, 0);
    chk("basic_err",  frameError, 0);
    tick(1);
    serialLatch = 1'b0;
    tick(4);
    consume();
    chk("basic_consumed", out_if.outValid, 0);

    // Random frames
    for (int i = 0; i < 3; i++) begin
      f = frame_t'($urandom);
      send(f, LB);
      chk("rand_cnt", bitCount, LB);
      latch();
      chk("rand_data",  out_if.dataOut, 64'(f));
      chk("rand_valid", out_if.outValid, 1);
      chk("rand_cnt0",  bitCount, 0);
      consume();
      chk("rand_consumed", out_if.outValid, 0);
    end
    chk("rand_err", frameError, 0);

    // Back-pressure
    fa = frame_t'($urandom);
    fb = ~fa;
    send(fa, LB);
    latch();
    chk("bp_a_valid", out_if.outValid, 1);
    send(fb, LB);
    latch();
    chk("bp_pend_data",  out_if.dataOut, 64'(fa));
    chk("bp_pend_valid", out_if.outValid, 1);
    chk("bp_pend_cnt",   bitCount, LB);
    tick(5);
    chk("bp_hold_data",  out_if.dataOut, 64'(fa));
    out_if.outReady = 1'b1;
    tick(1);
    out_if.outReady = 1'b0;
    chk("bp_b_data",  out_if.dataOut, 64'(fb));
    chk("bp_b_valid", out_if.outValid, 1);
    chk("bp_b_cnt",   bitCount, 0);
    consume();
    chk("bp_consumed", out_if.outValid, 0);
    chk("bp_err", frameError, 0);

    // Short frame, then a good frame with sticky error
    f = frame_t'($urandom);
    send(f, 10);
    chk("short_cnt10", bitCount, 10);
    latch();
    chk("short_err",   frameError, 1);
    chk("short_valid", out_if.outValid, 0);
    chk("short_cnt",   bitCount, 0);
    f = frame_t'($urandom);
    send(f, LB);
    latch();
    chk("after_short_data",  out_if.dataOut, 64'(f));
    chk("after_short_valid", out_if.outValid, 1);
    chk("after_short_err",   frameError, 1);

    // Reset mid-frame with an unconsumed frame held
    send(frame_t'($urandom), 7);
    chk("mid_cnt7", bitCount, 7);
    do_reset();
    chk("mid_rst_data",  out_if.dataOut, 0);
    chk("mid_rst_valid", out_if.outValid, 0);
    chk("mid_rst_err",   frameError, 0);
    chk("mid_rst_cnt",   bitCount, 0);
    f = frame_t'($urandom);
    send(f, LB);
    latch();
    chk("mid_full_data", out_if.dataOut, 64'(f));
    chk("mid_full_err",  frameError, 0);
    consume();

    // Overflow: 17th edge dropped
    f = frame_t'($urandom);
    send(f, LB + 1);
    chk("ovf_cnt", bitCount, LB);
    chk("ovf_err", frameError, 1);
    latch();
    chk("ovf_data",  out_if.dataOut, 64'(f));
    chk("ovf_valid", out_if.outValid, 1);
    consume();

    // Simultaneous 16th clock edge and latch
    do_reset();
    f = frame_t'($urandom);
    send(f, LB - 1);
    chk("sim_cnt15", bitCount, LB - 1);
    serialData = bits_at(f, LB - 1);
    tick(1);
    serialClock = 1'b1;
    serialLatch = 1'b1;
    tick(4);
    serialClock = 1'b0;
    serialLatch = 1'b0;
    tick(4);
    chk("sim_cnt",   bitCount, 0);
    chk("sim_err",   frameError, 1);
    chk("sim_valid", out_if.outValid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
